// File: rtl/axi4_lite_if.sv
// ============================================================================
//  Module   : axi4_lite_if
//  Brief    : AXI4-Lite bus bundle with master and slave modports.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32
);
    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport mst_port (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slv_port (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axi4_lite_slv_reg_bank.sv
// ============================================================================
//  Module   : axi4_lite_slv_reg_bank
//  Brief    : AXI4-Lite slave register bank with byte strobes, SLVERR decode
//             and per-register write pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_slv_reg_bank #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int NUM_REGS       = 16,
    parameter logic [NUM_REGS*DATA_BIT_WIDTH-1:0] REG_RST_VAL = '0
) (
    input  logic                                clk,
    input  logic                                sync_rst,
    axi4_lite_if.slv_port                       axi_if,
    output logic [NUM_REGS*DATA_BIT_WIDTH-1:0]  regs_out,
    output logic [NUM_REGS-1:0]                 wr_pulse
);
    localparam int                        STRB_W   = DATA_BIT_WIDTH / 8;
    localparam int                        ADDR_LSB = $clog2(STRB_W);
    localparam logic [ADDR_BIT_WIDTH-1:0] c_num_regs   = ADDR_BIT_WIDTH'(NUM_REGS);
    localparam logic [1:0]                c_resp_okay  = 2'b00;
    localparam logic [1:0]                c_resp_slverr = 2'b10;

    // Channel state: each flag is one bit of a 1-2 state machine
    logic                        r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic                        r_awready, r_wready, r_arready;
    logic [ADDR_BIT_WIDTH-1:0]   r_awaddr;
    logic [DATA_BIT_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]           r_wstrb;
    logic [1:0]                  r_bresp, r_rresp;
    logic [DATA_BIT_WIDTH-1:0]   r_rdata;
    logic [DATA_BIT_WIDTH-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]         r_wr_pulse;

    logic                        w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic                        w_nxt_aw_held, w_nxt_w_held, w_nxt_bvalid, w_nxt_rvalid;
    logic [ADDR_BIT_WIDTH-1:0]   w_aw_idx, w_ar_idx;
    logic                        w_aw_ok, w_ar_ok;
    logic [DATA_BIT_WIDTH-1:0]   w_rd_data;
    logic                        w_unused_prot;

    assign w_unused_prot = ^{axi_if.awprot, axi_if.arprot};

    // Next-state logic
    always_comb begin
        w_aw_hs  = axi_if.awvalid & r_awready;
        w_w_hs   = axi_if.wvalid  & r_wready;
        w_ar_hs  = axi_if.arvalid & r_arready;
        w_commit = r_aw_held & r_w_held & ~r_bvalid;

        w_aw_idx = r_awaddr >> ADDR_LSB;
        w_ar_idx = axi_if.araddr >> ADDR_LSB;
        w_aw_ok  = (w_aw_idx < c_num_regs);
        w_ar_ok  = (w_ar_idx < c_num_regs);

        w_nxt_aw_held = r_aw_held;
        w_nxt_w_held  = r_w_held;
        if (w_commit) begin
            w_nxt_aw_held = 1'b0;
            w_nxt_w_held  = 1'b0;
        end else begin
            if (w_aw_hs) w_nxt_aw_held = 1'b1;
            if (w_w_hs)  w_nxt_w_held  = 1'b1;
        end
        w_nxt_bvalid = w_commit | (r_bvalid & ~axi_if.bready);
        w_nxt_rvalid = w_ar_hs  | (r_rvalid & ~axi_if.rready);

        // Out-of-range index matches no register, so the mux yields zero
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == ADDR_BIT_WIDTH'(i)) w_rd_data = r_regs[i];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_arready  <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= c_resp_okay;
            r_rresp    <= c_resp_okay;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= REG_RST_VAL[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
            end
        end else begin
            r_aw_held <= w_nxt_aw_held;
            r_w_held  <= w_nxt_w_held;
            r_bvalid  <= w_nxt_bvalid;
            r_rvalid  <= w_nxt_rvalid;
            r_awready <= ~w_nxt_aw_held;
            r_wready  <= ~w_nxt_w_held;
            r_arready <= ~w_nxt_rvalid;

            if (w_aw_hs) r_awaddr <= axi_if.awaddr;
            if (w_w_hs) begin
                r_wdata <= axi_if.wdata;
                r_wstrb <= axi_if.wstrb;
            end
            if (w_commit) r_bresp <= w_aw_ok ? c_resp_okay : c_resp_slverr;

            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && w_aw_ok && (w_aw_idx == ADDR_BIT_WIDTH'(i))) begin
                    r_wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (r_wstrb[b]) r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
                    end
                end
            end

            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_ar_ok ? c_resp_okay : c_resp_slverr;
            end
        end
    end

    // Outputs
    assign axi_if.awready = r_awready;
    assign axi_if.wready  = r_wready;
    assign axi_if.bvalid  = r_bvalid;
    assign axi_if.bresp   = r_bresp;
    assign axi_if.arready = r_arready;
    assign axi_if.rvalid  = r_rvalid;
    assign axi_if.rdata   = r_rdata;
    assign axi_if.rresp   = r_rresp;
    assign wr_pulse       = r_wr_pulse;

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = r_regs[i];
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_slv_reg_bank.sv
// ============================================================================
//  Module   : tb_axi4_lite_slv_reg_bank
//  Brief    : Directed self-checking bench for axi4_lite_slv_reg_bank.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_lite_slv_reg_bank;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR*DW-1:0] RST_VAL =
        {{12{32'h0}}, 32'hDEADBEEF, 32'h0, 32'h11223344, 32'h0};

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*DW-1:0] regs_out;
    logic [NR-1:0]    wr_pulse;
    logic [DW-1:0]    exp_regs [NR];
    int               n_chk = 0;
    int               n_bad = 0;

    axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) m ();

    axi4_lite_slv_reg_bank #(
        .ADDR_BIT_WIDTH(AW),
        .DATA_BIT_WIDTH(DW),
        .NUM_REGS(NR),
        .REG_RST_VAL(RST_VAL)
    ) dut (
        .clk(clk),
        .sync_rst(rst),
        .axi_if(m),
        .regs_out(regs_out),
        .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dreg(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    function automatic logic [NR*DW-1:0] packed_model();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = exp_regs[i];
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        exp_regs[1] = 32'h11223344;
        exp_regs[3] = 32'hDEADBEEF;
    endtask

    // Issues AW and W together and returns once both have handshaked
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int cnt = 0;
        m.awaddr = addr; m.wdata = data; m.wstrb = strb;
        m.awvalid = 1'b1; m.wvalid = 1'b1;
        while (!(aw_done && w_done) && cnt < 50) begin
            aw_now = m.awvalid && m.awready;
            w_now  = m.wvalid && m.wready;
            @(posedge clk); #1;
            if (aw_now) begin aw_done = 1; m.awvalid = 1'b0; end
            if (w_now)  begin w_done = 1;  m.wvalid  = 1'b0; end
            cnt++;
        end
        m.awvalid = 1'b0; m.wvalid = 1'b0;
        check_val("wr_handshake", {62'd0, aw_done, w_done}, 64'd3);
    endtask

    task automatic wait_b(input logic [1:0] exp_resp, input string tag);
        int cnt = 0;
        m.bready = 1'b1;
        while (!m.bvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
        check_val({tag, "_bvalid"}, m.bvalid, 1);
        check_val({tag, "_bresp"}, m.bresp, exp_resp);
        @(posedge clk); #1;
        m.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp);
        int cnt = 0;
        bit ok = 0;
        m.araddr = addr; m.arvalid = 1'b1;
        while (!ok && cnt < 50) begin ok = m.arready; @(posedge clk); #1; cnt++; end
        m.arvalid = 1'b0;
        check_val("ar_handshake", ok, 1);
        cnt = 0;
        m.rready = 1'b1;
        while (!m.rvalid && cnt < 50) begin @(posedge clk); #1; cnt++; end
        check_val("rvalid_seen", m.rvalid, 1);
        data = m.rdata; resp = m.rresp;
        @(posedge clk); #1;
        m.rready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [1:0]    rr;
        int            nresp;
        bit            flag;

        rst = 1'b1;
        m.awaddr = '0; m.awprot = '0; m.awvalid = 1'b0;
        m.wdata = '0;  m.wstrb = '0;  m.wvalid = 1'b0; m.bready = 1'b0;
        m.araddr = '0; m.arprot = '0; m.arvalid = 1'b0; m.rready = 1'b0;
        reset_model();

        // Reset: two edges with sync_rst high
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_readies", {m.awready, m.wready, m.arready}, 0);
        check_val("rst_valids", {m.bvalid, m.rvalid}, 0);
        check_val("rst_pulse", wr_pulse, 0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("post_rst_readies", {m.awready, m.wready, m.arready}, 3'b111);
        check_val("post_rst_regs", (regs_out == RST_VAL), 1);
        axi_read(32'h0C, rd, rr);
        check_val("rst_rd_reg3", rd, 32'hDEADBEEF);
        check_val("rst_rd_resp", rr, 2'b00);

        // Full write with exact latency, then read back
        @(posedge clk); #1;
        m.awaddr = 32'h08; m.wdata = 32'h12345678; m.wstrb = 4'hF;
        m.awvalid = 1'b1; m.wvalid = 1'b1;
        @(posedge clk); #1;
        m.awvalid = 1'b0; m.wvalid = 1'b0;
        @(negedge clk);
        check_val("lat_bvalid_t0", m.bvalid, 0);
        @(posedge clk); @(negedge clk);
        check_val("lat_bvalid_t1", m.bvalid, 1);
        check_val("lat_bresp", m.bresp, 2'b00);
        check_val("lat_pulse", wr_pulse, 16'h0004);
        check_val("lat_reg2", dreg(2), 32'h12345678);
        @(posedge clk); @(negedge clk);
        check_val("lat_pulse_end", wr_pulse, 0);
        check_val("lat_bvalid_hold", m.bvalid, 1);
        m.bready = 1'b1;
        @(posedge clk); #1;
        m.bready = 1'b0;
        @(negedge clk);
        check_val("lat_bvalid_clr", m.bvalid, 0);
        exp_regs[2] = 32'h12345678;
        axi_read(32'h08, rd, rr);
        check_val("rd_reg2", rd, 32'h12345678);
        check_val("rd_reg2_resp", rr, 2'b00);

        // Strobes with W ahead of AW
        @(posedge clk); #1;
        m.wdata = 32'hAABBCCDD; m.wstrb = 4'h5; m.wvalid = 1'b1;
        @(posedge clk); #1;
        m.wvalid = 1'b0;
        @(negedge clk);
        check_val("w_held_readies", {m.awready, m.wready}, 2'b10);
        @(posedge clk); @(posedge clk); #1;
        m.awaddr = 32'h04; m.awvalid = 1'b1;
        @(posedge clk); #1;
        m.awvalid = 1'b0;
        wait_b(2'b00, "strb");
        exp_regs[1] = 32'h11BB33DD;
        check_val("strb_reg1", dreg(1), exp_regs[1]);

        // Write backpressure: three writes with bready low
        m.bready = 1'b0;
        axi_write(32'h10, 32'h0000000A, 4'hF);
        axi_write(32'h14, 32'h0000000B, 4'hF);
        nresp = 0;
        fork
            axi_write(32'h18, 32'h0000000C, 4'hF);
            begin
                repeat (10) @(negedge clk);
                check_val("bp_readies", {m.awready, m.wready}, 0);
                check_val("bp_bvalid", m.bvalid, 1);
                check_val("bp_reg5_pending", dreg(5), 0);
                m.bready = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    if (m.bvalid) begin
                        nresp++;
                        check_val("bp_bresp", m.bresp, 2'b00);
                    end
                    @(negedge clk);
                end
                m.bready = 1'b0;
            end
        join
        check_val("bp_nresp", nresp, 3);
        exp_regs[4] = 32'hA; exp_regs[5] = 32'hB; exp_regs[6] = 32'hC;
        check_val("bp_regs", (regs_out == packed_model()), 1);

        // Read backpressure: rdata must hold while a write lands underneath
        @(posedge clk); #1;
        m.araddr = 32'h10; m.arvalid = 1'b1; m.rready = 1'b0;
        @(posedge clk); #1;
        m.arvalid = 1'b0;
        axi_write(32'h10, 32'h00000055, 4'hF);
        wait_b(2'b00, "rbp_w");
        exp_regs[4] = 32'h55;
        @(negedge clk);
        check_val("rbp_rvalid", m.rvalid, 1);
        check_val("rbp_rdata", m.rdata, 32'hA);
        check_val("rbp_arready", m.arready, 0);
        check_val("rbp_reg4", dreg(4), 32'h55);
        m.rready = 1'b1;
        @(posedge clk); #1;
        m.rready = 1'b0;
        @(negedge clk);
        check_val("rbp_rvalid_clr", m.rvalid, 0);

        // Out-of-range write and read
        flag = 0;
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF);
        repeat (3) begin @(negedge clk); if (wr_pulse != 0) flag = 1; end
        wait_b(2'b10, "err_w");
        check_val("err_no_pulse", flag, 0);
        check_val("err_regs", (regs_out == packed_model()), 1);
        axi_read(32'h1000, rd, rr);
        check_val("err_rdata", rd, 0);
        check_val("err_rresp", rr, 2'b10);

        // Reset while a response is pending and a write is held
        m.bready = 1'b0;
        axi_write(32'h1C, 32'h77, 4'hF);
        axi_write(32'h20, 32'h88, 4'hF);
        @(negedge clk);
        check_val("rr_pre_bvalid", m.bvalid, 1);
        check_val("rr_pre_awready", m.awready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_model();
        flag = 0;
        repeat (5) begin @(negedge clk); if (m.bvalid || wr_pulse != 0) flag = 1; end
        check_val("rr_no_resp", flag, 0);
        check_val("rr_regs", (regs_out == packed_model()), 1);
        @(posedge clk); #1;
        m.wdata = 32'h99; m.wstrb = 4'hF; m.wvalid = 1'b1;
        @(posedge clk); #1;
        m.wvalid = 1'b0;
        flag = 0;
        repeat (3) begin @(negedge clk); if (m.bvalid) flag = 1; end
        check_val("rr_w_alone", flag, 0);
        @(posedge clk); #1;
        m.awaddr = 32'h20; m.awvalid = 1'b1;
        @(posedge clk); #1;
        m.awvalid = 1'b0;
        wait_b(2'b00, "rr_w");
        exp_regs[8] = 32'h99;
        check_val("rr_reg8", dreg(8), 32'h99);

        // Read sampled on the same edge as a commit to reg0
        axi_write(32'h00, 32'h0BADF00D, 4'hF);
        wait_b(2'b00, "se_pre");
        m.awaddr = 32'h00; m.wdata = 32'hCAFEBABE; m.wstrb = 4'hF;
        m.awvalid = 1'b1; m.wvalid = 1'b1;
        @(posedge clk); #1;
        m.awvalid = 1'b0; m.wvalid = 1'b0;
        m.araddr = 32'h00; m.arvalid = 1'b1;
        @(posedge clk); #1;
        m.arvalid = 1'b0;
        @(negedge clk);
        check_val("se_rvalid", m.rvalid, 1);
        check_val("se_rdata_old", m.rdata, 32'h0BADF00D);
        check_val("se_reg0_new", dreg(0), 32'hCAFEBABE);
        check_val("se_bvalid", m.bvalid, 1);
        m.rready = 1'b1; m.bready = 1'b1;
        @(posedge clk); #1;
        m.rready = 1'b0; m.bready = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
